frame_sync_check: RTL

//  Parametrised successor of the fixed 25-frame packet checker in the SerDes RX path; sits after the descrambler.

---
 rtl/frame_sync_check_if.sv | 41 ++++
 rtl/frame_sync_check.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_check_if.sv
// ============================================================================
// Module      : frame_sync_check_if
// Description : Data/status bundle between the descrambler-side driver and
//               frame_sync_check.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface frame_sync_check_if #(
    parameter int DATA_W    = 62,
    parameter int IDX_W     = 5,
    parameter int PKT_CNT_W = 30,
    parameter int ERR_CNT_W = 16
);
    logic                 data_valid;
    logic [DATA_W-1:0]    unscrambled_data;
    logic                 data_packet_start;
    logic                 err_cnt_clr;
    logic [IDX_W-1:0]     frame_idx;
    logic                 frame_tail_flag;
    logic                 frame_tail_error;
    logic [PKT_CNT_W-1:0] packet_count;
    logic                 packet_count_overflow;
    logic [ERR_CNT_W-1:0] tail_err_count;
    logic                 restart_flag;
    logic                 locked;

    modport master (
        output data_valid, unscrambled_data, data_packet_start, err_cnt_clr,
        input  frame_idx, frame_tail_flag, frame_tail_error, packet_count,
               packet_count_overflow, tail_err_count, restart_flag, locked
    );

    modport slave (
        input  data_valid, unscrambled_data, data_packet_start, err_cnt_clr,
        output frame_idx, frame_tail_flag, frame_tail_error, packet_count,
               packet_count_overflow, tail_err_count, restart_flag, locked
    );
endinterface

`default_nettype wire

// File: rtl/frame_sync_check.sv
// ============================================================================
// Module      : frame_sync_check
// Description : Per-packet header/body/tail tracker with tail-pattern check,
//               packet/error counters and frame-alignment lock FSM.
//               Optional error counter: FRAME_SYNC_CHECK_STATS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module frame_sync_check #(
    parameter int                DATA_W        = 62,
    parameter int                BODY_FRAMES   = 25,
    parameter int                TAIL_W        = 4,
    parameter logic [TAIL_W-1:0] TAIL_PATTERN  = 4'b0011,
    parameter int                PKT_CNT_W     = 30,
    parameter int                ERR_CNT_W     = 16,
    parameter int                LOCK_THRESH   = 4,
    parameter int                UNLOCK_THRESH = 2,
    localparam int               IDX_W         = $clog2(BODY_FRAMES + 2)
) (
    input  wire logic          clk_390p625M,
    input  wire logic          rst,
    frame_sync_check_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BODY = 2'd1;
    localparam logic [1:0] S_TAIL = 2'd2;

    localparam logic [IDX_W-1:0] IDX_FIRST     = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST_BODY = IDX_W'(BODY_FRAMES);
    localparam logic [IDX_W-1:0] IDX_TAIL      = IDX_W'(BODY_FRAMES + 1);

    localparam int GOOD_W = $clog2(LOCK_THRESH + 1);
    localparam int BAD_W  = $clog2(UNLOCK_THRESH + 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_THRESH);
    localparam logic [BAD_W-1:0]  BAD_MAX  = BAD_W'(UNLOCK_THRESH);

    logic [1:0]           state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic                 tail_flag;
    logic                 tail_err;
    logic [PKT_CNT_W-1:0] pkt_cnt;
    logic                 pkt_ovf;
    logic                 restart;
    logic                 lock;
    logic [GOOD_W-1:0]    good_run, good_inc;
    logic [BAD_W-1:0]     bad_run, bad_inc;

    logic start_beat, tail_beat, tail_match, abort, good_tail, bad_event;
    logic unused_data;

    assign start_beat = bus.data_valid && bus.data_packet_start;
    assign tail_beat  = bus.data_valid && (state == S_TAIL);
    assign tail_match = (bus.unscrambled_data[TAIL_W-1:0] == TAIL_PATTERN);
    assign abort      = start_beat && (state == S_BODY);
    assign good_tail  = tail_beat && tail_match;
    // A restart inside a packet is treated exactly like a failed tail.
    assign bad_event  = (tail_beat && !tail_match) || abort;
    assign unused_data = ^bus.unscrambled_data[DATA_W-1:TAIL_W];

    always_ff @(posedge clk_390p625M) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (bus.data_valid) begin
            case (state)
                S_IDLE: begin
                    if (bus.data_packet_start) begin
                        state_nxt = S_BODY;
                        idx_nxt   = IDX_FIRST;
                    end
                end
                S_BODY: begin
                    if (bus.data_packet_start) begin
                        idx_nxt = IDX_FIRST;
                    end else if (idx == IDX_LAST_BODY) begin
                        state_nxt = S_TAIL;
                        idx_nxt   = IDX_TAIL;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
                S_TAIL: begin
                    if (bus.data_packet_start) begin
                        state_nxt = S_BODY;
                        idx_nxt   = IDX_FIRST;
                    end else begin
                        state_nxt = S_IDLE;
                        idx_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        tail_flag = (state == S_TAIL);
    end

    always_comb begin
        good_inc = (good_run == GOOD_MAX) ? GOOD_MAX : good_run + GOOD_W'(1);
        bad_inc  = (bad_run == BAD_MAX) ? BAD_MAX : bad_run + BAD_W'(1);
    end

    always_ff @(posedge clk_390p625M) begin
        if (rst) begin
            tail_err <= 1'b0;
            pkt_cnt  <= '0;
            pkt_ovf  <= 1'b0;
            restart  <= 1'b0;
            lock     <= 1'b0;
            good_run <= '0;
            bad_run  <= '0;
        end else begin
            restart <= abort;
            if (tail_beat) begin
                tail_err <= !tail_match;
            end
            // Once wrapped, the next header restarts the count at 1.
            if (start_beat) begin
                if (pkt_ovf) begin
                    pkt_ovf <= 1'b0;
                    pkt_cnt <= PKT_CNT_W'(1);
                end else begin
                    pkt_ovf <= &pkt_cnt;
                    pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
                end
            end
            if (good_tail) begin
                good_run <= good_inc;
                bad_run  <= '0;
                if (good_inc == GOOD_MAX) begin
                    lock <= 1'b1;
                end
            end else if (bad_event) begin
                bad_run  <= bad_inc;
                good_run <= '0;
                if (bad_inc == BAD_MAX) begin
                    lock <= 1'b0;
                end
            end
        end
    end

`ifdef FRAME_SYNC_CHECK_STATS_EN
    logic [ERR_CNT_W-1:0] err_cnt;

    always_ff @(posedge clk_390p625M) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (bus.err_cnt_clr) begin
            err_cnt <= '0;
        end else if (bad_event && !(&err_cnt)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    assign bus.tail_err_count = err_cnt;
`else
    logic unused_clr;
    assign unused_clr         = bus.err_cnt_clr;
    assign bus.tail_err_count = '0;
`endif

    assign bus.frame_idx             = idx;
    assign bus.frame_tail_flag       = tail_flag;
    assign bus.frame_tail_error      = tail_err;
    assign bus.packet_count          = pkt_cnt;
    assign bus.packet_count_overflow = pkt_ovf;
    assign bus.restart_flag          = restart;
    assign bus.locked                = lock;

endmodule

`default_nettype wire
